// File: rtl/cpu_control_fsm.sv
// Multicycle control sequencer: steps each instruction through fetch, IR load,
// decode and one or two execute states, driving datapath enables and mux selects.
module cpu_control_fsm #(
    parameter int OP_CODE_BITS     = 4,
    parameter int EXT_OP_CODE_BITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [OP_CODE_BITS-1:0]     op_code,
    input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
    input  logic                        cond_true,
    input  logic                        stall,
    output logic                        ir_en,
    output logic                        pc_en,
    output logic [1:0]                  pc_src,
    output logic                        mem_addr_sel,
    output logic                        mem_we,
    output logic                        reg_we,
    output logic [1:0]                  wb_sel,
    output logic                        alu_src_imm,
    output logic                        flags_en,
    output logic                        instr_done,
    output logic                        illegal_op
);

    typedef enum logic [3:0] {
        FETCH, IR_LOAD, DECODE, EXEC_ALU, EXEC_LUI, LOAD_ADDR,
        LOAD_WB, STORE, BRANCH, JCOND, JAL
    } state_t;

    localparam logic [OP_CODE_BITS-1:0] OP_ALU  = OP_CODE_BITS'(4'h0);
    localparam logic [OP_CODE_BITS-1:0] OP_ANDI = OP_CODE_BITS'(4'h1);
    localparam logic [OP_CODE_BITS-1:0] OP_ORI  = OP_CODE_BITS'(4'h2);
    localparam logic [OP_CODE_BITS-1:0] OP_XORI = OP_CODE_BITS'(4'h3);
    localparam logic [OP_CODE_BITS-1:0] OP_EXT  = OP_CODE_BITS'(4'h4);
    localparam logic [OP_CODE_BITS-1:0] OP_ADDI = OP_CODE_BITS'(4'h5);
    localparam logic [OP_CODE_BITS-1:0] OP_SUBI = OP_CODE_BITS'(4'h9);
    localparam logic [OP_CODE_BITS-1:0] OP_CMPI = OP_CODE_BITS'(4'hB);
    localparam logic [OP_CODE_BITS-1:0] OP_BCC  = OP_CODE_BITS'(4'hC);
    localparam logic [OP_CODE_BITS-1:0] OP_MOVI = OP_CODE_BITS'(4'hD);
    localparam logic [OP_CODE_BITS-1:0] OP_LUI  = OP_CODE_BITS'(4'hF);

    localparam logic [EXT_OP_CODE_BITS-1:0] EXT_LOAD  = EXT_OP_CODE_BITS'(4'h0);
    localparam logic [EXT_OP_CODE_BITS-1:0] EXT_STORE = EXT_OP_CODE_BITS'(4'h4);
    localparam logic [EXT_OP_CODE_BITS-1:0] EXT_JAL   = EXT_OP_CODE_BITS'(4'h8);
    localparam logic [EXT_OP_CODE_BITS-1:0] EXT_CMP   = EXT_OP_CODE_BITS'(4'hB);
    localparam logic [EXT_OP_CODE_BITS-1:0] EXT_JCOND = EXT_OP_CODE_BITS'(4'hC);

    state_t state, state_next;
    logic   is_imm, is_cmp;

    assign is_imm = (op_code == OP_ANDI) || (op_code == OP_ORI)  || (op_code == OP_XORI) ||
                    (op_code == OP_ADDI) || (op_code == OP_SUBI) || (op_code == OP_CMPI) ||
                    (op_code == OP_MOVI);
    assign is_cmp = (op_code == OP_CMPI) || ((op_code == OP_ALU) && (ext_op_code == EXT_CMP));

    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else if (!stall)
            state <= state_next;
    end

    always_comb begin
        state_next   = FETCH;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        pc_src       = 2'd0;
        mem_addr_sel = 1'b0;
        mem_we       = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        alu_src_imm  = 1'b0;
        flags_en     = 1'b0;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;

        case (state)
            FETCH: state_next = IR_LOAD;
            IR_LOAD: begin
                ir_en      = 1'b1;
                pc_en      = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (op_code == OP_ALU || is_imm)
                    state_next = EXEC_ALU;
                else if (op_code == OP_LUI)
                    state_next = EXEC_LUI;
                else if (op_code == OP_BCC)
                    state_next = BRANCH;
                else if (op_code == OP_EXT && ext_op_code == EXT_LOAD)
                    state_next = LOAD_ADDR;
                else if (op_code == OP_EXT && ext_op_code == EXT_STORE)
                    state_next = STORE;
                else if (op_code == OP_EXT && ext_op_code == EXT_JCOND)
                    state_next = JCOND;
                else if (op_code == OP_EXT && ext_op_code == EXT_JAL)
                    state_next = JAL;
                else begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            EXEC_ALU: begin
                flags_en    = 1'b1;
                alu_src_imm = is_imm;
                reg_we      = !is_cmp;
                instr_done  = 1'b1;
            end
            EXEC_LUI: begin
                reg_we     = 1'b1;
                wb_sel     = 2'd3;
                instr_done = 1'b1;
            end
            LOAD_ADDR: begin
                mem_addr_sel = 1'b1;
                state_next   = LOAD_WB;
            end
            LOAD_WB: begin
                mem_addr_sel = 1'b1;
                reg_we       = 1'b1;
                wb_sel       = 2'd1;
                instr_done   = 1'b1;
            end
            STORE: begin
                mem_addr_sel = 1'b1;
                mem_we       = 1'b1;
                instr_done   = 1'b1;
            end
            BRANCH: begin
                pc_en      = cond_true;
                pc_src     = 2'd1;
                instr_done = 1'b1;
            end
            JCOND: begin
                pc_en      = cond_true;
                pc_src     = 2'd2;
                instr_done = 1'b1;
            end
            JAL: begin
                // PC reads B before the register write lands, so A == B is safe.
                reg_we     = 1'b1;
                wb_sel     = 2'd2;
                pc_en      = 1'b1;
                pc_src     = 2'd2;
                instr_done = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // Stall freezes side effects but leaves selects steady; reset also clears selects.
        if (stall || reset) begin
            ir_en      = 1'b0;
            pc_en      = 1'b0;
            mem_we     = 1'b0;
            reg_we     = 1'b0;
            flags_en   = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
        if (reset) begin
            pc_src       = 2'd0;
            mem_addr_sel = 1'b0;
            wb_sel       = 2'd0;
            alu_src_imm  = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: per-instruction expected cycle sequences
// are queued by the stimulus and compared by an independent negedge monitor.
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cond_true = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] op_code = 4'h0;
    logic [3:0] ext_op_code = 4'h0;
    logic       ir_en, pc_en, mem_addr_sel, mem_we, reg_we;
    logic       alu_src_imm, flags_en, instr_done, illegal_op;
    logic [1:0] pc_src, wb_sel;

    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       mem_addr_sel;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       alu_src_imm;
        logic       flags_en;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    outs_t act;
    outs_t exp_q[$];
    string tag_q[$];
    outs_t seq_q[$];
    outs_t mon_e;
    string mon_t;
    int    checks = 0;
    int    failures = 0;

    cpu_control_fsm #(.OP_CODE_BITS(4), .EXT_OP_CODE_BITS(4)) dut (
        .clk(clk), .reset(reset), .op_code(op_code), .ext_op_code(ext_op_code),
        .cond_true(cond_true), .stall(stall), .ir_en(ir_en), .pc_en(pc_en),
        .pc_src(pc_src), .mem_addr_sel(mem_addr_sel), .mem_we(mem_we),
        .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm),
        .flags_en(flags_en), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign act = {ir_en, pc_en, pc_src, mem_addr_sel, mem_we, reg_we, wb_sel,
                  alu_src_imm, flags_en, instr_done, illegal_op};

    // Monitor: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if (act !== mon_e) begin
                failures++;
                $display("FAIL %s: got %b required %b (ir pc src mas mwe rwe wb imm fl done ill)",
                         mon_t, act, mon_e);
            end
        end
    end

    task automatic step(input logic rst, input logic stl, input outs_t e, input string t);
        reset = rst;
        stall = stl;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    // Reference: the cycle-by-cycle output sequence of one instruction, by class.
    task automatic build(input logic [15:0] instr, input logic cond);
        logic [3:0] op, ext;
        outs_t      o;
        bit         imm;
        op  = instr[15:12];
        ext = instr[7:4];
        imm = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
        seq_q.delete();
        seq_q.push_back('0);
        o = '0; o.ir_en = 1'b1; o.pc_en = 1'b1;
        seq_q.push_back(o);
        o = '0;
        if (op == 4'h0 || imm) begin
            seq_q.push_back('0);
            o.flags_en = 1'b1; o.alu_src_imm = imm; o.instr_done = 1'b1;
            o.reg_we = !(op == 4'hB || (op == 4'h0 && ext == 4'hB));
            seq_q.push_back(o);
        end else if (op == 4'hF) begin
            seq_q.push_back('0);
            o.reg_we = 1'b1; o.wb_sel = 2'd3; o.instr_done = 1'b1;
            seq_q.push_back(o);
        end else if (op == 4'h4 && ext == 4'h0) begin
            seq_q.push_back('0);
            o.mem_addr_sel = 1'b1;
            seq_q.push_back(o);
            o.reg_we = 1'b1; o.wb_sel = 2'd1; o.instr_done = 1'b1;
            seq_q.push_back(o);
        end else if (op == 4'h4 && ext == 4'h4) begin
            seq_q.push_back('0);
            o.mem_addr_sel = 1'b1; o.mem_we = 1'b1; o.instr_done = 1'b1;
            seq_q.push_back(o);
        end else if (op == 4'h4 && ext == 4'hC) begin
            seq_q.push_back('0);
            o.pc_en = cond; o.pc_src = 2'd2; o.instr_done = 1'b1;
            seq_q.push_back(o);
        end else if (op == 4'h4 && ext == 4'h8) begin
            seq_q.push_back('0);
            o.reg_we = 1'b1; o.wb_sel = 2'd2; o.pc_en = 1'b1; o.pc_src = 2'd2;
            o.instr_done = 1'b1;
            seq_q.push_back(o);
        end else if (op == 4'hC) begin
            seq_q.push_back('0);
            o.pc_en = cond; o.pc_src = 2'd1; o.instr_done = 1'b1;
            seq_q.push_back(o);
        end else begin
            o.illegal_op = 1'b1; o.instr_done = 1'b1;
            seq_q.push_back(o);
        end
    endtask

    task automatic run_instr(input logic [15:0] instr, input logic cond, input int stall_at,
                             input int stall_n, input bit rnd, input int abort_at);
        outs_t s;
        int    n;
        build(instr, cond);
        op_code     = instr[15:12];
        ext_op_code = instr[7:4];
        cond_true   = cond;
        for (int i = 0; i < seq_q.size(); i++) begin
            if (i == abort_at) begin
                step(1'b1, 1'($urandom_range(0, 1)), '0, $sformatf("%h reset_abort c%0d", instr, i));
                return;
            end
            n = (i == stall_at) ? stall_n : 0;
            if (rnd && $urandom_range(0, 4) == 0) n += $urandom_range(1, 2);
            s = seq_q[i];
            s.ir_en = 1'b0; s.pc_en = 1'b0; s.mem_we = 1'b0; s.reg_we = 1'b0;
            s.flags_en = 1'b0; s.instr_done = 1'b0; s.illegal_op = 1'b0;
            repeat (n) step(1'b0, 1'b1, s, $sformatf("%h stall c%0d", instr, i));
            step(1'b0, 1'b0, seq_q[i], $sformatf("%h c%0d", instr, i));
        end
    endtask

    initial begin
        logic [3:0]  op, ext;
        logic [15:0] instr;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, '0, "reset_cycle1");
        step(1'b1, 1'b0, '0, "reset_cycle2");
        step(1'b1, 1'b1, '0, "reset_over_stall");

        run_instr(16'h5307, 1'b0, -1, 0, 1'b0, -1);   // ADDI
        run_instr(16'hB307, 1'b0, -1, 0, 1'b0, -1);   // CMPI
        run_instr(16'h00B3, 1'b0, -1, 0, 1'b0, -1);   // CMP
        run_instr(16'h0023, 1'b0, -1, 0, 1'b0, -1);   // register ALU
        run_instr(16'hF312, 1'b0, -1, 0, 1'b0, -1);   // LUI
        run_instr(16'h4201, 1'b0, -1, 0, 1'b0, -1);   // LOAD
        run_instr(16'h4241, 1'b0, -1, 0, 1'b0, -1);   // STORE
        run_instr(16'hC0FE, 1'b1, -1, 0, 1'b0, -1);   // BRANCH taken
        run_instr(16'hC0FE, 1'b0, -1, 0, 1'b0, -1);   // BRANCH not taken
        run_instr(16'h41C2, 1'b1, -1, 0, 1'b0, -1);   // JCOND taken
        run_instr(16'h41C2, 1'b0, -1, 0, 1'b0, -1);   // JCOND not taken
        run_instr(16'h4E83, 1'b0, -1, 0, 1'b0, -1);   // JAL
        run_instr(16'h7000, 1'b0, -1, 0, 1'b0, -1);   // illegal op
        run_instr(16'h4010, 1'b0, -1, 0, 1'b0, -1);   // illegal ext
        run_instr(16'h4241, 1'b0, 3, 3, 1'b0, -1);    // STORE stalled 3 cycles
        run_instr(16'h4201, 1'b0, 4, 2, 1'b0, -1);    // LOAD stalled in writeback
        run_instr(16'h4E83, 1'b0, 3, 0, 1'b0, 3);     // JAL abandoned by reset

        for (int k = 0; k < 300; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h4)
                ext = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3) * 4);
            else if (op == 4'h0 && $urandom_range(0, 2) == 0)
                ext = 4'hB;
            else
                ext = 4'($urandom);
            instr = {op, 4'($urandom), ext, 4'($urandom)};
            run_instr(instr, 1'($urandom_range(0, 1)), -1, 0, 1'b1,
                      ($urandom_range(0, 11) == 0) ? $urandom_range(1, 4) : -1);
        end

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
